// File: rtl/instruction_fetch_pkg.sv
// Shared types and widths for the instruction-fetch slice.
// Optional feature macro used by this slice: IFETCH_BOUND_CHECK_EN.
package instruction_fetch_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Return buffer for fetched words: DEPTH x WIDTH synchronous FIFO with push/pop/clear.
// Clear wins over push and pop; head data reads as zero while empty.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the word PC, issues 1-cycle memory reads under a credit limit,
// buffers returns for decode. IFETCH_BOUND_CHECK_EN swaps PC wrap for a sticky range fault.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int RESET_PC   = 0,
  parameter int MEM_DEPTH  = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   mem_pc,
  input  logic [INST_W-1:0] mem_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              redir_valid,
  input  logic [PC_W-1:0]   redir_pc,
  input  logic              halt,
  output logic              fault
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t                    state_q, state_d;
  logic [PC_W-1:0]           mem_pc_q, mem_pc_d;
  logic [PC_W-1:0]           pc_q, pc_d;
  logic                      issue_q, issue_d;
  logic                      inflight_q, inflight_d;
  logic                      push, pop, credit_ok;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_empty;
  logic [PC_W+INST_W-1:0]    fifo_rdata;

`ifdef IFETCH_BOUND_CHECK_EN
  logic fault_q, fault_d;

  function automatic logic [PC_W-1:0] wrap_pc(input logic [PC_W-1:0] p);
    return p;
  endfunction
`else
  localparam logic [PC_W-1:0] PC_MASK = PC_W'(MEM_DEPTH - 1);

  function automatic logic [PC_W-1:0] wrap_pc(input logic [PC_W-1:0] p);
    return p & PC_MASK;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    mem_pc_d   = mem_pc_q;
    pc_d       = mem_pc_q;
    inflight_d = issue_q;
    issue_d    = 1'b0;
    pop        = out_valid & out_ready & ~redir_valid;
    push       = inflight_q & ~redir_valid;
`ifdef IFETCH_BOUND_CHECK_EN
    fault_d    = fault_q;
`endif
    // Count buffered words plus every request still able to return after this edge.
    credit_ok = (32'(fifo_count) + 32'(inflight_q) + 32'(issue_q) - 32'(pop))
                < 32'(FIFO_DEPTH);

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt) state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    if (issue_q) mem_pc_d = wrap_pc(mem_pc_q + 32'd1);

    if (redir_valid) begin
      state_d    = ST_RUN;
      mem_pc_d   = wrap_pc(redir_pc);
      inflight_d = 1'b0;
      issue_d    = 1'b1;
    end else begin
      issue_d = (state_d == ST_RUN) && credit_ok;
    end

`ifdef IFETCH_BOUND_CHECK_EN
    if (redir_valid) fault_d = 1'b0;
    if ((state_d == ST_RUN) && (mem_pc_d >= PC_W'(MEM_DEPTH))) begin
      fault_d = 1'b1;
      state_d = ST_HALT;
      issue_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      mem_pc_q   <= PC_W'(RESET_PC);
      issue_q    <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_pc_q   <= mem_pc_d;
      issue_q    <= issue_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef IFETCH_BOUND_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // PC tag of the read in flight; only meaningful while inflight_q is set.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PC_W + INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redir_valid),
    .wdata ({pc_q, mem_inst}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign mem_pc    = mem_pc_q;
  assign out_valid = ~fifo_empty;
  assign out_pc    = fifo_rdata[INST_W +: PC_W];
  assign out_inst  = fifo_rdata[INST_W-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed-plus-random bench for instruction_fetch: a word-stream model tracks the next pc
// decode must see, and every accepted word is checked against it and the memory image.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] mem_pc;
  logic [31:0] mem_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        halt;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  logic [31:0] imem [128];
  logic [31:0] exp_pc;
  logic [31:0] frozen_pc;

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .mem_pc      (mem_pc),
    .mem_inst    (mem_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .halt        (halt),
    .fault       (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: one-cycle registered read of the requested word.
  always @(posedge clk) mem_inst <= imem[mem_pc[6:0]];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] p);
`ifdef IFETCH_BOUND_CHECK_EN
    return p + 32'd1;
`else
    return (p + 32'd1) % 32'd128;
`endif
  endfunction

  // One clock: score the transfer happening this cycle, advance, then check hold/range rules.
  task automatic tick();
    logic        xfer, hold;
    logic [31:0] hpc, hinst;
    xfer  = out_valid && out_ready && !redir_valid && !rst;
    hold  = out_valid && !out_ready && !redir_valid && !rst;
    hpc   = out_pc;
    hinst = out_inst;
    if (xfer) begin
      check("xfer_pc", out_pc, exp_pc);
      check("xfer_inst", out_inst, imem[exp_pc[6:0]]);
      exp_pc = next_pc(exp_pc);
      delivered++;
    end
    if (redir_valid) begin
`ifdef IFETCH_BOUND_CHECK_EN
      exp_pc = redir_pc;
`else
      exp_pc = redir_pc % 32'd128;
`endif
    end
    @(posedge clk);
    #1;
    redir_valid = 1'b0;
    if (hold) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_pc", out_pc, hpc);
      check("hold_inst", out_inst, hinst);
    end
`ifndef IFETCH_BOUND_CHECK_EN
    check("pc_range", mem_pc & ~32'h7F, 32'd0);
    check("fault_tied", {31'd0, fault}, 32'd0);
`endif
  endtask

  task automatic redirect(input logic [31:0] target);
    redir_valid = 1'b1;
    redir_pc    = target;
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    out_ready   = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'd0;
    halt        = 1'b0;
    exp_pc      = 32'd0;
    for (int i = 0; i < 128; i++) imem[i] = $urandom;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mem_pc", mem_pc, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);

    // Test 1: first word after three edges, then an in-order stream
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    check("boot_valid_1", {31'd0, out_valid}, 32'd0);
    tick();
    check("boot_valid_2", {31'd0, out_valid}, 32'd0);
    tick();
    check("boot_valid_3", {31'd0, out_valid}, 32'd1);
    check("boot_first_pc", out_pc, 32'd0);
    check("boot_first_inst", out_inst, imem[0]);
    repeat (12) tick();
    check("stream_progress", {31'd0, delivered >= 4}, 32'd1);

    // Test 2: decode stall freezes outputs and request pointer
    out_ready = 1'b0;
    repeat (3) tick();
    frozen_pc = mem_pc;
    repeat (2) tick();
    check("stall_mem_pc", mem_pc, frozen_pc);
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 25; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Test 3: redirect discards buffered and in-flight words
    out_ready = 1'b0;
    repeat (4) tick();
    out_ready = 1'b1;
    redirect(32'd40);
    check("redir_valid_1", {31'd0, out_valid}, 32'd0);
    tick();
    check("redir_valid_2", {31'd0, out_valid}, 32'd0);
    tick();
    check("redir_valid_3", {31'd0, out_valid}, 32'd1);
    check("redir_first_pc", out_pc, 32'd40);
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Test 4: halt at pc 5, drain, resume by redirect to 9
    out_ready = 1'b1;
    redirect(32'd2);
    for (int i = 0; i < 40 && mem_pc != 32'd5; i++) tick();
    check("reach_pc5", mem_pc, 32'd5);
    halt = 1'b1;
    repeat (8) tick();
    check("halt_drained", {31'd0, out_valid}, 32'd0);
    check("halt_all_delivered", exp_pc, mem_pc);
    check("halt_stop_pc", {31'd0, (mem_pc == 32'd5) || (mem_pc == 32'd6)}, 32'd1);
    frozen_pc = mem_pc;
    repeat (3) tick();
    check("halt_mem_pc", mem_pc, frozen_pc);
    halt = 1'b0;
    redirect(32'd9);
    repeat (2) tick();
    check("resume_valid", {31'd0, out_valid}, 32'd1);
    check("resume_pc", out_pc, 32'd9);
    repeat (6) tick();

    // Test 5: end of memory
    redirect(32'd124);
    repeat (30) tick();
`ifdef IFETCH_BOUND_CHECK_EN
    check("bound_fault", {31'd0, fault}, 32'd1);
    check("bound_mem_pc", mem_pc, 32'd128);
    check("bound_drained", {31'd0, out_valid}, 32'd0);
    check("bound_all_delivered", exp_pc, 32'd128);
    redirect(32'd0);
    check("bound_fault_clear", {31'd0, fault}, 32'd0);
    repeat (10) tick();
`else
    check("wrap_passed_zero", {31'd0, exp_pc < 32'd124}, 32'd1);
`endif

    // Test 6: asynchronous reset with words buffered, then restart
    out_ready = 1'b0;
    repeat (4) tick();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_mem_pc", mem_pc, 32'd0);
    check("async_rst_out_pc", out_pc, 32'd0);
    exp_pc = 32'd0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    check("reboot_valid_1", {31'd0, out_valid}, 32'd0);
    tick();
    check("reboot_valid_2", {31'd0, out_valid}, 32'd0);
    tick();
    check("reboot_valid_3", {31'd0, out_valid}, 32'd1);
    check("reboot_first_pc", out_pc, 32'd0);
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
